// File: rtl/line_raster_engine_if.sv
// line_raster_engine_if: command, status and framebuffer write bundle
// between the edge sequencer, the rasteriser and the framebuffer port.
interface line_raster_engine_if #(
   parameter int COORD_W = 8,
   parameter int COLOR_W = 8
);
   logic                   start;
   logic [COORD_W-1:0]     x0;
   logic [COORD_W-1:0]     y0;
   logic [COORD_W-1:0]     x1;
   logic [COORD_W-1:0]     y1;
   logic [COLOR_W-1:0]     color;
   logic                   busy;
   logic                   done;
   logic [2*COORD_W-1:0]   fb_addr;
   logic [COLOR_W-1:0]     fb_data;
   logic                   w_en;
   logic                   w_ready;

   modport master (
      output start, x0, y0, x1, y1, color, w_ready,
      input  busy, done, fb_addr, fb_data, w_en
   );

   modport slave (
      input  start, x0, y0, x1, y1, color, w_ready,
      output busy, done, fb_addr, fb_data, w_en
   );
endinterface

// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham rasteriser for all eight octants,
// one framebuffer write per pixel, honouring write backpressure.
module line_raster_engine #(
   parameter int COORD_W = 8,
   parameter int COLOR_W = 8
) (
   input  logic clk,
   input  logic rst,
   line_raster_engine_if.slave bus
);
   localparam int ADDR_W = 2 * COORD_W;
   localparam int D_W    = COORD_W + 1;
   localparam int E_W    = COORD_W + 2;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

   state_t state, state_nxt;

   logic [COORD_W-1:0]    x0_q, y0_q, x1_q, y1_q;
   logic [COORD_W-1:0]    cur_x, cur_y;
   logic [COLOR_W-1:0]    color_q;
   logic [D_W-1:0]        dx, dy;
   logic                  sx_pos, sy_pos;
   logic signed [E_W-1:0] err;

   logic [D_W-1:0]        dx_init, dy_init;
   logic signed [E_W-1:0] err_init;
   logic signed [E_W:0]   e2, dx_s, dy_s;
   logic signed [E_W-1:0] dx_term, dy_term, err_nxt;
   logic                  step_x, step_y;
   logic                  draw, accept, last;
   logic [ADDR_W-1:0]     addr;

   assign draw   = (state == DRAW);
   assign accept = draw && bus.w_ready;
   assign last   = (cur_x == x1_q) && (cur_y == y1_q);
   assign addr   = {cur_x, cur_y};

   always_comb begin
      dx_init  = (x1_q >= x0_q) ? D_W'(x1_q - x0_q) : D_W'(x0_q - x1_q);
      dy_init  = (y1_q >= y0_q) ? D_W'(y1_q - y0_q) : D_W'(y0_q - y1_q);
      err_init = $signed({1'b0, dx_init}) - $signed({1'b0, dy_init});
   end

   // e2 needs one extra bit over err; the err update itself cannot overflow
   always_comb begin
      e2      = $signed({err, 1'b0});
      dx_s    = $signed({2'b00, dx});
      dy_s    = $signed({2'b00, dy});
      step_x  = (e2 >= -dy_s);
      step_y  = (e2 <= dx_s);
      dy_term = step_x ? $signed({1'b0, dy}) : '0;
      dx_term = step_y ? $signed({1'b0, dx}) : '0;
      err_nxt = err - dy_term + dx_term;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = SETUP;
         SETUP:   state_nxt = DRAW;
         DRAW:    if (accept && last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         dx      <= '0;
         dy      <= '0;
         sx_pos  <= 1'b0;
         sy_pos  <= 1'b0;
         err     <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               x0_q    <= bus.x0;
               y0_q    <= bus.y0;
               x1_q    <= bus.x1;
               y1_q    <= bus.y1;
               color_q <= bus.color;
            end
            SETUP: begin
               dx     <= dx_init;
               dy     <= dy_init;
               sx_pos <= (x0_q < x1_q);
               sy_pos <= (y0_q < y1_q);
               err    <= err_init;
               cur_x  <= x0_q;
               cur_y  <= y0_q;
            end
            // the endpoint check keeps cur from ever stepping past it
            DRAW: if (accept && !last) begin
               err <= err_nxt;
               if (step_x)
                  cur_x <= sx_pos ? cur_x + COORD_W'(1) : cur_x - COORD_W'(1);
               if (step_y)
                  cur_y <= sy_pos ? cur_y + COORD_W'(1) : cur_y - COORD_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == SETUP) || draw;
   assign bus.done    = (state == DONE);
   assign bus.w_en    = draw;
   assign bus.fb_addr = addr;
   assign bus.fb_data = color_q;
endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: directed scenario tasks for the rasteriser,
// with a negedge monitor logging accepted writes and done pulses.
`timescale 1ns/1ps
module tb_line_raster_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [15:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int          wr_cyc[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        done_busy = 1'b0;

   line_raster_engine_if bus();

   line_raster_engine dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.w_en && bus.w_ready) begin
         wr_addr.push_back(bus.fb_addr);
         wr_data.push_back(bus.fb_data);
         wr_cyc.push_back(cyc);
      end
      if (bus.done) begin
         done_cnt  = done_cnt + 1;
         done_cyc  = cyc;
         done_busy = bus.busy;
      end
   end

   task automatic start_line(input logic [7:0] ax0, input logic [7:0] ay0,
                             input logic [7:0] ax1, input logic [7:0] ay1,
                             input logic [7:0] c, output int t0);
      bus.x0 = ax0;
      bus.y0 = ay0;
      bus.x1 = ax1;
      bus.y1 = ay1;
      bus.color = c;
      bus.start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done_cnt > d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.w_ready = 1'b1;
      start_line(8'd1, 8'd2, 8'd3, 8'd4, 8'h11, cyc);
      bus.start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got busy=%b done=%b w_en=%b exp 0/0/0",
                  bus.busy, bus.done, bus.w_en);
      end
      n_cmp++;
      if (bus.fb_addr !== 16'h0000 || bus.fb_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_bus got addr=%h data=%h exp 0000/00",
                  bus.fb_addr, bus.fb_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || wr_addr.size() != 0 || done_cnt != 0) begin
         n_bad++;
         $display("FAIL reset_start_ignored got busy=%b writes=%0d done=%0d exp 0/0/0",
                  bus.busy, wr_addr.size(), done_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_horizontal();
      int t0, b, d0;
      bit ok;
      logic [15:0] e;
      b = wr_addr.size();
      d0 = done_cnt;
      start_line(8'd0, 8'd0, 8'd3, 8'd0, 8'hFF, t0);
      wait_done(d0, 20, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL horiz_done got none exp pulse");
      end
      n_cmp++;
      if (wr_addr.size() - b != 4) begin
         n_bad++;
         $display("FAIL horiz_count got %0d exp 4", wr_addr.size() - b);
      end
      for (int i = 0; i < 4; i++) begin
         if (b + i < wr_addr.size()) begin
            e = {i[7:0], 8'h00};
            n_cmp++;
            if (wr_addr[b+i] !== e || wr_data[b+i] !== 8'hFF || wr_cyc[b+i] != t0 + 2 + i) begin
               n_bad++;
               $display("FAIL horiz_px%0d got %h/%h@%0d exp %h/ff@%0d", i,
                        wr_addr[b+i], wr_data[b+i], wr_cyc[b+i] - t0, e, 2 + i);
            end
         end
      end
      n_cmp++;
      if (done_cyc != t0 + 6 || done_cnt - d0 != 1 || done_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL horiz_done_timing got cyc=%0d n=%0d busy=%b exp 6/1/0",
                  done_cyc - t0, done_cnt - d0, done_busy);
      end
   endtask

   task automatic test_steep_reverse();
      int t0, b, d0;
      bit ok;
      logic [15:0] e [6] = '{16'h0505, 16'h0504, 16'h0403,
                             16'h0402, 16'h0301, 16'h0300};
      b = wr_addr.size();
      d0 = done_cnt;
      start_line(8'd5, 8'd5, 8'd3, 8'd0, 8'h42, t0);
      wait_done(d0, 30, ok);
      n_cmp++;
      if (!ok || wr_addr.size() - b != 6 || done_cnt - d0 != 1) begin
         n_bad++;
         $display("FAIL steep_count got writes=%0d done=%0d exp 6/1",
                  wr_addr.size() - b, done_cnt - d0);
      end
      for (int i = 0; i < 6; i++) begin
         if (b + i < wr_addr.size()) begin
            n_cmp++;
            if (wr_addr[b+i] !== e[i]) begin
               n_bad++;
               $display("FAIL steep_px%0d got %h exp %h", i, wr_addr[b+i], e[i]);
            end
         end
      end
   endtask

   task automatic test_point();
      int t0, b, d0;
      bit ok;
      b = wr_addr.size();
      d0 = done_cnt;
      start_line(8'd7, 8'd9, 8'd7, 8'd9, 8'hA5, t0);
      wait_done(d0, 10, ok);
      n_cmp++;
      if (!ok || wr_addr.size() - b != 1) begin
         n_bad++;
         $display("FAIL point_count got %0d exp 1", wr_addr.size() - b);
      end
      if (wr_addr.size() > b) begin
         n_cmp++;
         if (wr_addr[b] !== 16'h0709 || wr_data[b] !== 8'hA5 || wr_cyc[b] != t0 + 2) begin
            n_bad++;
            $display("FAIL point_px got %h/%h@%0d exp 0709/a5@2",
                     wr_addr[b], wr_data[b], wr_cyc[b] - t0);
         end
      end
      n_cmp++;
      if (done_cyc != t0 + 3 || done_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL point_done got cyc=%0d busy=%b exp 3/0",
                  done_cyc - t0, done_busy);
      end
   endtask

   task automatic test_backpressure();
      int t0, b, d0;
      bit ok;
      logic [15:0] e [3] = '{16'h0000, 16'h0101, 16'h0202};
      b = wr_addr.size();
      d0 = done_cnt;
      start_line(8'd0, 8'd0, 8'd2, 8'd2, 8'h3C, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.w_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.w_en !== 1'b1 || bus.fb_addr !== 16'h0101 || bus.fb_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL stall_hold%0d got w_en=%b addr=%h data=%h exp 1/0101/3c",
                     i, bus.w_en, bus.fb_addr, bus.fb_data);
         end
         @(posedge clk); #1;
      end
      bus.w_ready = 1'b1;
      wait_done(d0, 20, ok);
      n_cmp++;
      if (!ok || wr_addr.size() - b != 3 || done_cyc != t0 + 8) begin
         n_bad++;
         $display("FAIL stall_result got writes=%0d done_cyc=%0d exp 3/8",
                  wr_addr.size() - b, done_cyc - t0);
      end
      for (int i = 0; i < 3; i++) begin
         if (b + i < wr_addr.size()) begin
            n_cmp++;
            if (wr_addr[b+i] !== e[i]) begin
               n_bad++;
               $display("FAIL stall_px%0d got %h exp %h", i, wr_addr[b+i], e[i]);
            end
         end
      end
      if (b + 1 < wr_addr.size()) begin
         n_cmp++;
         if (wr_cyc[b+1] != t0 + 6) begin
            n_bad++;
            $display("FAIL stall_accept_cyc got %0d exp 6", wr_cyc[b+1] - t0);
         end
      end
   endtask

   task automatic test_full_diagonal();
      int t0, b, d0, bad_px;
      bit ok;
      logic [7:0] k;
      b = wr_addr.size();
      d0 = done_cnt;
      bad_px = 0;
      start_line(8'd255, 8'd255, 8'd0, 8'd0, 8'h81, t0);
      repeat (50) begin
         @(posedge clk); #1;
      end
      start_line(8'd10, 8'd10, 8'd20, 8'd20, 8'h01, t0);
      wait_done(d0, 400, ok);
      n_cmp++;
      if (!ok || wr_addr.size() - b != 256) begin
         n_bad++;
         $display("FAIL diag_count got %0d exp 256", wr_addr.size() - b);
      end
      for (int i = 0; i < 256; i++) begin
         if (b + i < wr_addr.size()) begin
            k = 8'(255 - i);
            if (wr_addr[b+i] !== {k, k} || wr_data[b+i] !== 8'h81) bad_px++;
         end
      end
      n_cmp++;
      if (bad_px != 0) begin
         n_bad++;
         $display("FAIL diag_pixels got %0d wrong exp 0", bad_px);
      end
      n_cmp++;
      if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 16'h0000) begin
         n_bad++;
         $display("FAIL diag_last got %h exp 0000",
                  wr_addr.size() ? wr_addr[wr_addr.size()-1] : 16'hxxxx);
      end
      repeat (5) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || done_cnt - d0 != 1 || wr_addr.size() - b != 256) begin
         n_bad++;
         $display("FAIL diag_start_ignored got busy=%b done=%0d writes=%0d exp 0/1/256",
                  bus.busy, done_cnt - d0, wr_addr.size() - b);
      end
   endtask

   task automatic test_reset_abort();
      int t0, b, d0;
      bit ok;
      logic [15:0] e [3] = '{16'h0101, 16'h0201, 16'h0301};
      b = wr_addr.size();
      d0 = done_cnt;
      start_line(8'd0, 8'd0, 8'd9, 8'd0, 8'h55, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.w_en !== 1'b0 || bus.busy !== 1'b0 || bus.fb_addr !== 16'h0000) begin
         n_bad++;
         $display("FAIL abort_state got w_en=%b busy=%b addr=%h exp 0/0/0000",
                  bus.w_en, bus.busy, bus.fb_addr);
      end
      repeat (15) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (done_cnt != d0 || wr_addr.size() - b != 3) begin
         n_bad++;
         $display("FAIL abort_no_done got done=%0d writes=%0d exp 0/3",
                  done_cnt - d0, wr_addr.size() - b);
      end
      b = wr_addr.size();
      start_line(8'd1, 8'd1, 8'd3, 8'd1, 8'h77, t0);
      wait_done(d0, 20, ok);
      n_cmp++;
      if (!ok || wr_addr.size() - b != 3 || done_cyc != t0 + 5) begin
         n_bad++;
         $display("FAIL abort_fresh got writes=%0d done_cyc=%0d exp 3/5",
                  wr_addr.size() - b, done_cyc - t0);
      end
      for (int i = 0; i < 3; i++) begin
         if (b + i < wr_addr.size()) begin
            n_cmp++;
            if (wr_addr[b+i] !== e[i] || wr_data[b+i] !== 8'h77) begin
               n_bad++;
               $display("FAIL fresh_px%0d got %h/%h exp %h/77",
                        i, wr_addr[b+i], wr_data[b+i], e[i]);
            end
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.x0 = '0;
      bus.y0 = '0;
      bus.x1 = '0;
      bus.y1 = '0;
      bus.color = '0;
      bus.w_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_horizontal();
      test_steep_reverse();
      test_point();
      test_backpressure();
      test_full_diagonal();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end
endmodule
